reg_file_8x16: RTL and testbench
================================

// Module: reg_file_8x16
// PURPOSE
//   8-entry x 16-bit register file: the stage directly downstream of the 16-bit
//   2:1 write-back mux. The mux output (ALU result or switch data) lands on wr_data.
//   Two combinational read ports feed the ALU operands and the display path.
//   Built-in sweep-clear FSM zeroes all entries on request without a reset.
// PARAMETERS
//   DATA_W   16  data width of each entry
//   ADDR_W   3   address width (2**ADDR_W entries)
//   BYPASS   1   1: read port returns wr_data when its address is being written this cycle
//   R0_ZERO  0   1: entry 0 always reads 0; writes to it are dropped
// PORTS
//   clk         in   1       system clock, rising edge
//   reset_n     in   1       asynchronous, active-low reset
//   wr_valid    in   1       write request
//   wr_ready    out  1       block can accept a write (high only in IDLE)
//   wr_addr     in   ADDR_W  write address
//   wr_data     in   DATA_W  write data (from write-back mux Y)
//   clr_req     in   1       request sweep-clear of all entries (level, sampled in IDLE)
//   clr_busy    out  1       sweep-clear in progress
//   clr_done    out  1       one-cycle pulse after final entry cleared
//   rd_addr_a   in   ADDR_W  read port A address
//   rd_data_a   out  DATA_W  read port A data (combinational)
//   rd_addr_b   in   ADDR_W  read port B address
//   rd_data_b   out  DATA_W  read port B data (combinational)
// BEHAVIOUR
//   - Reset (reset_n=0, async): all entries 0, state IDLE, sweep counter 0,
//     clr_busy=0, clr_done=0, wr_ready=1; rd_data_a/b therefore 0 (or bypass value).
//   - States: IDLE, CLEAR.
//   - IDLE: wr_ready=1. Write fires when wr_valid & wr_ready at rising clk edge;
//     entry[wr_addr] <= wr_data, visible on read ports from the next cycle (latency 1).
//   - IDLE & clr_req=1 at edge -> CLEAR, counter=0. Write firing on same edge still
//     completes; the sweep then zeroes it (clear wins).
//   - CLEAR: wr_ready=0, clr_busy=1; each cycle entry[counter] <= 0, counter++.
//     After entry 2**ADDR_W-1 cleared -> IDLE, clr_done=1 for exactly that next
//     cycle, counter back to 0. Sweep length = 2**ADDR_W cycles (8 by default).
//   - wr_valid during CLEAR: not accepted, requester holds request (valid/ready rule);
//     clr_req during CLEAR ignored, no re-trigger.
//   - clr_req held high across return to IDLE starts a new sweep on that IDLE cycle.
//   - Reads: rd_data_x = entry[rd_addr_x], purely combinational, both ports independent;
//     same address on both ports legal.
//   - BYPASS=1: if write fires this cycle and rd_addr_x==wr_addr, rd_data_x=wr_data.
//     No bypass of sweep zeroing; reads in CLEAR return stored contents.
//   - R0_ZERO=1: rd_addr_x==0 -> 0 (overrides bypass); writes to addr 0 discarded.
//   - Reset asserted mid-sweep: immediate return to IDLE, all entries 0, clr_done not
//     pulsed.
//   - Writes with wr_valid & ~wr_ready are never partially applied.
// TESTING
//   1. Reset, write 0xA5A5 to R3 then 0x1234 to R5 -> next cycle rd_a(3)=0xA5A5, rd_b(5)=0x1234.
//   2. BYPASS=1: write 0xBEEF to R2 with rd_addr_a=2 -> rd_data_a=0xBEEF in same cycle;
//      BYPASS=0 -> old value until next cycle.
//   3. Fill R0..R7 with 0x1111*i, pulse clr_req -> clr_busy=1 for 8 cycles, wr_ready=0,
//      clr_done=1 one cycle, then all reads 0.
//   4. Same edge wr_valid(R4,0x7777)+clr_req -> R4 ends 0; wr_valid held during CLEAR
//      is not written until wr_ready=1, then R4=held data.
//   5. Drop reset_n at sweep cycle 4 with R5..R7=0xFFFF -> immediately all 0,
//      IDLE, clr_busy=0, no clr_done.
//   6. R0_ZERO=1: write 0xFFFF to R0 -> rd_a(0)=0 even in write cycle; R1 unaffected.

Source files
------------

// File: rtl/reg_file_8x16.sv
// ---------------------------------------------------------------------------
// reg_file_8x16
//   8-entry x 16-bit register file fed by the write-back mux. One write port
//   (valid/ready), two independent combinational read ports (ALU operands and
//   display path), and a sweep-clear engine that zeroes every entry, one per
//   cycle, without needing a reset.
//
// Parameters
//   DATA_W   data width of each entry
//   ADDR_W   address width (2**ADDR_W entries)
//   BYPASS   1: a read port returns wr_data when its address is written this cycle
//   R0_ZERO  1: entry 0 always reads 0 and writes to it are dropped
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   wr_valid   in   write request
//   wr_ready   out  write accepted this cycle if valid (high only when idle)
//   wr_addr    in   write address
//   wr_data    in   write data
//   clr_req    in   sweep-clear request (level, sampled when idle)
//   clr_busy   out  sweep-clear in progress
//   clr_done   out  one-cycle pulse after the final entry is cleared
//   rd_addr_a  in   read port A address
//   rd_data_a  out  read port A data (combinational)
//   rd_addr_b  in   read port B address
//   rd_data_b  out  read port B data (combinational)
// ---------------------------------------------------------------------------
module reg_file_8x16 #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_clr_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wr_fire;
  logic                w_wr_drop;
  logic                w_last;
  logic [DATA_W-1:0]   w_rd_data_a;
  logic [DATA_W-1:0]   w_rd_data_b;

  assign wr_ready  = (r_state == ST_IDLE);
  assign clr_busy  = (r_state == ST_CLEAR);
  assign clr_done  = r_clr_done;
  assign w_wr_fire = wr_valid & wr_ready;
  assign w_last    = (r_cnt == ADDR_W'(DEPTH - 1));
  // Entry 0 is hard-wired to zero when R0_ZERO is set, so writes to it vanish.
  assign w_wr_drop = (R0_ZERO != 0) && (wr_addr == '0);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  // NOTE: next-state logic takes its default first so no path leaves
  // w_state_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (clr_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_last)  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Pulse lands on the first idle cycle after the last entry is zeroed.
      r_clr_done <= (r_state == ST_CLEAR) && w_last;
      // Counter wraps from DEPTH-1 back to 0 on its own as the sweep ends.
      if (r_state == ST_CLEAR) r_cnt <= r_cnt + 1'b1;
      else                     r_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the array is deliberately reset: a reset must leave every entry
  // reading zero, which a non-reset RAM macro could not guarantee.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire && !w_wr_drop) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports: stored value, optionally overridden by the in-flight write,
  // and finally forced to zero for entry 0 when it is hard-wired.
  // -------------------------------------------------------------------------
  always_comb begin
    w_rd_data_a = r_mem[rd_addr_a];
    if ((BYPASS != 0) && w_wr_fire && (rd_addr_a == wr_addr)) w_rd_data_a = wr_data;
    if ((R0_ZERO != 0) && (rd_addr_a == '0))                  w_rd_data_a = '0;
  end

  always_comb begin
    w_rd_data_b = r_mem[rd_addr_b];
    if ((BYPASS != 0) && w_wr_fire && (rd_addr_b == wr_addr)) w_rd_data_b = wr_data;
    if ((R0_ZERO != 0) && (rd_addr_b == '0))                  w_rd_data_b = '0;
  end

  assign rd_data_a = w_rd_data_a;
  assign rd_data_b = w_rd_data_b;

endmodule

// File: tb/tb_reg_file_8x16.sv
// ---------------------------------------------------------------------------
// tb_reg_file_8x16
//   Directed bench for reg_file_8x16. Two instances share all inputs:
//   u_dut uses the default parameters (BYPASS=1, R0_ZERO=0); u_alt uses
//   BYPASS=0, R0_ZERO=1. Inputs change 1 ns after the rising edge and
//   outputs are compared 1 ns later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_reg_file_8x16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_req;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;

  logic        wr_ready,  clr_busy,  clr_done;
  logic [15:0] rd_data_a, rd_data_b;
  logic        alt_wr_ready, alt_clr_busy, alt_clr_done;
  logic [15:0] alt_rd_data_a, alt_rd_data_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  reg_file_8x16 u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b)
  );

  reg_file_8x16 #(.BYPASS(0), .R0_ZERO(1)) u_alt (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (alt_wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_busy  (alt_clr_busy),
    .clr_done  (alt_clr_done),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (alt_rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (alt_rd_data_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic busy, input logic ready,
                            input logic done);
    check({tag, ".busy"},      16'(clr_busy),      16'(busy));
    check({tag, ".ready"},     16'(wr_ready),      16'(ready));
    check({tag, ".done"},      16'(clr_done),      16'(done));
    check({tag, ".alt_busy"},  16'(alt_clr_busy),  16'(busy));
    check({tag, ".alt_ready"}, 16'(alt_wr_ready),  16'(ready));
    check({tag, ".alt_done"},  16'(alt_clr_done),  16'(done));
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_req   = 1'b0;
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd5;

    // Reset state
    #2;
    check_ctrl("reset", 1'b0, 1'b1, 1'b0);
    check("reset.rd_a", rd_data_a, 16'h0000);
    check("reset.rd_b", rd_data_b, 16'h0000);
    #10 reset_n = 1'b1;
    tick();

    // 1: two writes, visible one cycle later
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5A5;
    tick();
    wr_addr = 3'd5; wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    #1;
    check("t1.rd_a3", rd_data_a, 16'hA5A5);
    check("t1.rd_b5", rd_data_b, 16'h1234);
    check("t1.alt_rd_a3", alt_rd_data_a, 16'hA5A5);
    check("t1.alt_rd_b5", alt_rd_data_b, 16'h1234);

    // 2: bypass vs. no bypass on a write to R2
    rd_addr_a = 3'd2;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
    #1;
    check("t2.bypass_same_cycle", rd_data_a, 16'hBEEF);
    check("t2.nobypass_same_cycle", alt_rd_data_a, 16'h0000);
    tick();
    wr_valid = 1'b0;
    #1;
    check("t2.bypass_next", rd_data_a, 16'hBEEF);
    check("t2.nobypass_next", alt_rd_data_a, 16'hBEEF);

    // 6: write 0xFFFF to R0; hard-wired instance keeps reading 0, R1 untouched
    rd_addr_a = 3'd0; rd_addr_b = 3'd1;
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    #1;
    check("t6.rd0_write_cycle", rd_data_a, 16'hFFFF);
    check("t6.alt_rd0_write_cycle", alt_rd_data_a, 16'h0000);
    tick();
    wr_valid = 1'b0;
    #1;
    check("t6.rd0_after", rd_data_a, 16'hFFFF);
    check("t6.alt_rd0_after", alt_rd_data_a, 16'h0000);
    check("t6.alt_rd1", alt_rd_data_b, 16'h0000);
    check("t6.rd1", rd_data_b, 16'h0000);

    // 3: fill R0..R7 with 0x1111*i, then sweep-clear
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h1111 * i);
      tick();
    end
    wr_valid = 1'b0;
    rd_addr_a = 3'd7; rd_addr_b = 3'd1;
    #1;
    check("t3.fill_rd7", rd_data_a, 16'h7777);
    check("t3.fill_rd1", rd_data_b, 16'h1111);
    rd_addr_a = 3'd0;
    #1;
    check("t3.alt_fill_rd0", alt_rd_data_a, 16'h0000);
    check("t3.fill_rd0", rd_data_a, 16'h0000);
    rd_addr_b = 3'd7;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_ctrl($sformatf("t3.sweep%0d", c), 1'b1, 1'b0, 1'b0);
      // R7 is the last entry zeroed, so it keeps its value through the sweep
      check($sformatf("t3.sweep%0d.rd7", c), rd_data_b, 16'h7777);
      tick();
    end
    #1;
    check_ctrl("t3.done", 1'b0, 1'b1, 1'b1);
    tick();
    check_ctrl("t3.after_done", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1;
      check($sformatf("t3.cleared_a%0d", i), rd_data_a, 16'h0000);
      check($sformatf("t3.cleared_b%0d", 7 - i), rd_data_b, 16'h0000);
      check($sformatf("t3.alt_cleared_a%0d", i), alt_rd_data_a, 16'h0000);
    end

    // 4: write + clear on the same edge; a new write is held through the sweep
    rd_addr_a = 3'd4;
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 16'h7777;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wr_data = 16'h4242;
    #1;
    check("t4.write_completed", rd_data_a, 16'h7777);
    for (int c = 0; c < 8; c++) begin
      // clr_req raised mid-sweep must not restart the sweep
      clr_req = (c == 3);
      #1;
      check($sformatf("t4.sweep%0d.ready", c), 16'(wr_ready), 16'h0000);
      tick();
    end
    clr_req = 1'b0;
    #1;
    check_ctrl("t4.done", 1'b0, 1'b1, 1'b1);
    check("t4.clear_won", alt_rd_data_a, 16'h0000);
    check("t4.bypass_held", rd_data_a, 16'h4242);
    tick();
    wr_valid = 1'b0;
    #1;
    check_ctrl("t4.no_retrigger", 1'b0, 1'b1, 1'b0);
    check("t4.held_written", rd_data_a, 16'h4242);
    check("t4.alt_held_written", alt_rd_data_a, 16'h4242);

    // 5: reset in the middle of a sweep with R5..R7 = 0xFFFF
    for (int i = 5; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 3'(i); wr_data = 16'hFFFF;
      tick();
    end
    wr_valid = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    rd_addr_a = 3'd6; rd_addr_b = 3'd7;
    #1;
    check("t5.pre_reset_rd6", rd_data_a, 16'hFFFF);
    check("t5.pre_reset_busy", 16'(clr_busy), 16'h0001);
    reset_n = 1'b0;
    #1;
    check_ctrl("t5.in_reset", 1'b0, 1'b1, 1'b0);
    check("t5.rd6", rd_data_a, 16'h0000);
    check("t5.rd7", rd_data_b, 16'h0000);
    rd_addr_a = 3'd5; rd_addr_b = 3'd4;
    #1;
    check("t5.rd5", rd_data_a, 16'h0000);
    check("t5.rd4", rd_data_b, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    check_ctrl("t5.after_reset", 1'b0, 1'b1, 1'b0);
    repeat (4) tick();
    check_ctrl("t5.no_done", 1'b0, 1'b1, 1'b0);

    // clr_req held high across the return to idle starts a new sweep
    clr_req = 1'b1;
    repeat (9) tick();
    check_ctrl("hold.done_cycle", 1'b0, 1'b1, 1'b1);
    tick();
    check_ctrl("hold.resweep", 1'b1, 1'b0, 1'b0);
    clr_req = 1'b0;
    repeat (8) tick();
    check_ctrl("hold.resweep_done", 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
